// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Handshake bundle between the hazard/debug sources and the pipeline control
// block.
//   master : drives debug_en, debug_step, mem_busy, load_use, branch_taken;
//            observes the control outputs and counters.
//   slave  : the pipeline_ctrl block itself (mirror of master).
// Parameters:
//   NREG  - number of pipeline registers (width of pipereg_we / pipereg_zero)
//   CNT_W - width of the performance counters
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int NREG  = 4,
  parameter int CNT_W = 16
);
  logic             debug_en;
  logic             debug_step;
  logic             mem_busy;
  logic             load_use;
  logic             branch_taken;
  logic             cpu_en;
  logic             pc_write;
  logic [NREG-1:0]  pipereg_we;
  logic [NREG-1:0]  pipereg_zero;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output debug_en, debug_step, mem_busy, load_use, branch_taken,
    input  cpu_en, pc_write, pipereg_we, pipereg_zero, stall_cnt, flush_cnt
  );

  modport slave (
    input  debug_en, debug_step, mem_busy, load_use, branch_taken,
    output cpu_en, pc_write, pipereg_we, pipereg_zero, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Stall / flush / single-step controller for an NREG-deep in-order pipeline.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - pipeline_ctrl_if.slave:
//            in : debug_en, debug_step (async button), mem_busy, load_use,
//                 branch_taken
//            out: cpu_en, pc_write, pipereg_we[NREG], pipereg_zero[NREG],
//                 stall_cnt, flush_cnt
// Parameters: NREG (3..8), BR_FLUSH (1..NREG-2), CNT_W.
// Optional feature: define PIPELINE_CTRL_PERF_EN to build the saturating
// stall/flush counters; otherwise both counters read as zero.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int NREG     = 4,
  parameter int BR_FLUSH = 1,
  parameter int CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, HALT, STEP} state_t;

  state_t     state_q;
  logic       sync1_q, sync2_q, prev_q;
  logic       armed_q;
  logic [1:0] fill_q;
  logic       step_edge;
  logic       cpu_en;

  // The edge detector is only armed after the synchronizer has carried a real
  // low sample; fill_q marks when sync2_q holds a genuine post-reset sample.
  // This keeps a button already held through reset from counting as a press.
  assign step_edge = sync2_q & ~prev_q & armed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= bus.debug_step;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & ~sync2_q);
      case (state_q)
        RUN:     if (bus.debug_en) state_q <= HALT;
        HALT: begin
          if (!bus.debug_en)  state_q <= RUN;
          else if (step_edge) state_q <= STEP;
        end
        STEP:    if (!bus.mem_busy) state_q <= HALT;
        default: state_q <= RUN;
      endcase
    end
  end

  assign cpu_en     = ((state_q == RUN) || (state_q == STEP)) && !rst;
  assign bus.cpu_en = cpu_en;

  // Priority rows: disabled, memory freeze, load-use bubble, branch flush, run.
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.pipereg_we   = '0;
    bus.pipereg_zero = '0;
    if (rst) begin
      bus.pipereg_zero = '1;
    end else if (!cpu_en || bus.mem_busy) begin
      bus.pipereg_zero = '0;
    end else if (bus.load_use) begin
      bus.pipereg_we      = '1;
      bus.pipereg_we[0]   = 1'b0;
      bus.pipereg_zero[1] = 1'b1;
    end else if (bus.branch_taken) begin
      bus.pc_write   = 1'b1;
      bus.pipereg_we = '1;
      for (int i = 0; i < NREG; i++) begin
        bus.pipereg_zero[i] = (i < BR_FLUSH);
      end
    end else begin
      bus.pc_write   = 1'b1;
      bus.pipereg_we = '1;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_ev, flush_ev;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign stall_ev = cpu_en && (bus.mem_busy || bus.load_use);
  assign flush_ev = cpu_en && !bus.mem_busy && !bus.load_use && bus.branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_ev) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic de, ds, mb, lu, bt;

  always #5 clk = ~clk;

  // dut1: default build; dut2: BR_FLUSH=2 and 4-bit counters
  pipeline_ctrl_if #(.NREG(4), .CNT_W(16)) if1 ();
  pipeline_ctrl_if #(.NREG(4), .CNT_W(4))  if2 ();

  assign if1.debug_en = de;  assign if2.debug_en = de;
  assign if1.debug_step = ds; assign if2.debug_step = ds;
  assign if1.mem_busy = mb;  assign if2.mem_busy = mb;
  assign if1.load_use = lu;  assign if2.load_use = lu;
  assign if1.branch_taken = bt; assign if2.branch_taken = bt;

  pipeline_ctrl #(.NREG(4), .BR_FLUSH(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  pipeline_ctrl #(.NREG(4), .BR_FLUSH(2), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       mb, lu, bt;
    logic       pc;
    logic [3:0] we, z1, z2;
  } vec_t;

  vec_t vecs[8];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; de = 0; ds = 0; mb = 0; lu = 0; bt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive a press of 'hold' cycles and count cpu_en cycles of dut1 in 'window'.
  task automatic press_count(input int hold, input int window, output int ones, output int first);
    ones = 0; first = -1;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      ds = (i < hold);
      #1;
      if (if1.cpu_en) begin
        ones++;
        if (first < 0) first = i;
      end
    end
    ds = 1'b0;
  endtask

  task automatic go_halt();
    @(negedge clk); de = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic go_run();
    @(negedge clk); de = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ones, first, found;
    int s1, f1, s2, f2;
    logic       e_pc;
    logic [3:0] e_we, e_z1, e_z2;

    vecs[0] = '{mb:0, lu:0, bt:0, pc:1, we:4'b1111, z1:4'b0000, z2:4'b0000};
    vecs[1] = '{mb:1, lu:0, bt:0, pc:0, we:4'b0000, z1:4'b0000, z2:4'b0000};
    vecs[2] = '{mb:0, lu:1, bt:0, pc:0, we:4'b1110, z1:4'b0010, z2:4'b0010};
    vecs[3] = '{mb:0, lu:0, bt:1, pc:1, we:4'b1111, z1:4'b0001, z2:4'b0011};
    vecs[4] = '{mb:0, lu:1, bt:1, pc:0, we:4'b1110, z1:4'b0010, z2:4'b0010};
    vecs[5] = '{mb:1, lu:0, bt:1, pc:0, we:4'b0000, z1:4'b0000, z2:4'b0000};
    vecs[6] = '{mb:1, lu:1, bt:1, pc:0, we:4'b0000, z1:4'b0000, z2:4'b0000};
    vecs[7] = '{mb:1, lu:1, bt:0, pc:0, we:4'b0000, z1:4'b0000, z2:4'b0000};

    // Reset and idle
    rst = 1'b1; de = 0; ds = 0; mb = 0; lu = 0; bt = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cpu_en", if1.cpu_en, 0);
    chk("rst_pc_write", if1.pc_write, 0);
    chk("rst_we", if1.pipereg_we, 4'b0000);
    chk("rst_zero", if1.pipereg_zero, 4'b1111);
    chk("rst_zero2", if2.pipereg_zero, 4'b1111);
    chk("rst_stall_cnt", if1.stall_cnt, 0);
    chk("rst_flush_cnt", if1.flush_cnt, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("idle_cpu_en", if1.cpu_en, 1);
    chk("idle_pc_write", if1.pc_write, 1);
    chk("idle_we", if1.pipereg_we, 4'b1111);
    chk("idle_zero", if1.pipereg_zero, 4'b0000);

    // Priority-row table
    foreach (vecs[i]) begin
      @(negedge clk);
      mb = vecs[i].mb; lu = vecs[i].lu; bt = vecs[i].bt;
      #1;
      chk($sformatf("vec%0d_pc", i), if1.pc_write, vecs[i].pc);
      chk($sformatf("vec%0d_we", i), if1.pipereg_we, vecs[i].we);
      chk($sformatf("vec%0d_z1", i), if1.pipereg_zero, vecs[i].z1);
      chk($sformatf("vec%0d_z2", i), if2.pipereg_zero, vecs[i].z2);
    end

    // Load-use stall for 2 cycles
    do_reset();
    @(negedge clk); lu = 1; #1;
    chk("lu1_pc", if1.pc_write, 0); chk("lu1_we", if1.pipereg_we, 4'b1110); chk("lu1_z", if1.pipereg_zero, 4'b0010);
    @(negedge clk); #1;
    chk("lu2_pc", if1.pc_write, 0); chk("lu2_we", if1.pipereg_we, 4'b1110); chk("lu2_z", if1.pipereg_zero, 4'b0010);
    @(negedge clk); lu = 0; #1;
    chk("lu_stall_cnt", if1.stall_cnt, PERF ? 2 : 0);

    // Branch alone, then branch with load-use
    @(negedge clk); bt = 1; #1;
    chk("br_z1", if1.pipereg_zero, 4'b0001); chk("br_z2", if2.pipereg_zero, 4'b0011); chk("br_pc", if1.pc_write, 1);
    @(negedge clk); lu = 1; #1;
    chk("brlu_we", if1.pipereg_we, 4'b1110); chk("brlu_z", if1.pipereg_zero, 4'b0010); chk("brlu_pc", if1.pc_write, 0);
    @(negedge clk); lu = 0; bt = 0; #1;
    chk("br_flush_cnt", if1.flush_cnt, PERF ? 1 : 0);
    chk("br_stall_cnt", if1.stall_cnt, PERF ? 3 : 0);

    // Single step
    go_halt(); #1;
    chk("halt_cpu_en", if1.cpu_en, 0);
    chk("halt_we", if1.pipereg_we, 4'b0000);
    press_count(5, 12, ones, first);
    chk("step1_cycles", ones, 1);
    chk("step1_latency", first, 3);
    press_count(5, 12, ones, first);
    chk("step2_cycles", ones, 1);
    go_run(); #1;
    chk("unhalt_cpu_en", if1.cpu_en, 1);

    // Step during a miss
    go_halt();
    @(negedge clk); mb = 1; ds = 1;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (if1.cpu_en) begin found = 1; break; end
    end
    chk("miss_step_entered", found, 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk($sformatf("miss%0d_cpu_en", k), if1.cpu_en, 1);
      chk($sformatf("miss%0d_we", k), if1.pipereg_we, 4'b0000);
    end
    @(negedge clk); mb = 0; ds = 0; #1;
    chk("miss_done_we", if1.pipereg_we, 4'b1111);
    @(negedge clk); #1;
    chk("miss_back_halt", if1.cpu_en, 0);

    // Reset mid-step with the button held through reset
    @(negedge clk); mb = 1; ds = 1;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (if1.cpu_en) begin found = 1; break; end
    end
    chk("abort_step_entered", found, 1);
    @(negedge clk); rst = 1; mb = 0; #1;
    chk("abort_cpu_en", if1.cpu_en, 0);
    chk("abort_zero", if1.pipereg_zero, 4'b1111);
    @(negedge clk); @(negedge clk); rst = 0; #1;
    chk("abort_run", if1.cpu_en, 1);
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (if1.cpu_en) ones++;
    end
    chk("preheld_no_step", ones, 0);
    @(negedge clk); ds = 0;
    repeat (3) @(negedge clk);
    press_count(2, 12, ones, first);
    chk("repress_step", ones, 1);
    go_run();

    // Saturation: 20 cycles of load-use
    do_reset();
    @(negedge clk); lu = 1;
    repeat (19) @(negedge clk);
    @(negedge clk); lu = 0; #1;
    chk("sat_stall_cnt4", if2.stall_cnt, PERF ? 15 : 0);
    chk("sat_stall_cnt16", if1.stall_cnt, PERF ? 20 : 0);

    // Random run-mode traffic against a priority-table model
    do_reset();
    s1 = 0; f1 = 0; s2 = 0; f2 = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      chk("rnd_stall1", if1.stall_cnt, PERF ? ((s1 > 65535) ? 65535 : s1) : 0);
      chk("rnd_flush1", if1.flush_cnt, PERF ? ((f1 > 65535) ? 65535 : f1) : 0);
      chk("rnd_stall2", if2.stall_cnt, PERF ? ((s2 > 15) ? 15 : s2) : 0);
      chk("rnd_flush2", if2.flush_cnt, PERF ? ((f2 > 15) ? 15 : f2) : 0);
      mb = ($urandom % 4) == 0;
      lu = ($urandom % 3) == 0;
      bt = ($urandom % 3) == 0;
      #1;
      if (mb) begin
        e_pc = 0; e_we = 4'b0000; e_z1 = 4'b0000; e_z2 = 4'b0000;
      end else if (lu) begin
        e_pc = 0; e_we = 4'b1111 & ~4'b0001; e_z1 = 4'b0010; e_z2 = 4'b0010;
      end else if (bt) begin
        e_pc = 1; e_we = 4'b1111; e_z1 = 4'((1 << 1) - 1); e_z2 = 4'((1 << 2) - 1);
      end else begin
        e_pc = 1; e_we = 4'b1111; e_z1 = 4'b0000; e_z2 = 4'b0000;
      end
      chk("rnd_pc", if1.pc_write, e_pc);
      chk("rnd_we", if1.pipereg_we, e_we);
      chk("rnd_z1", if1.pipereg_zero, e_z1);
      chk("rnd_z2", if2.pipereg_zero, e_z2);
      if (mb || lu) begin s1++; s2++; end
      else if (bt) begin f1++; f2++; end
    end
    @(negedge clk); mb = 0; lu = 0; bt = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
